// File: rtl/shoe_controller.sv
// rtl/shoe_controller.sv - card-shoe rank counters and round-robin draw arbiter
// Serves one card per grant from the ranks still left in a DECKS-deck shoe.
module shoe_controller #(
  parameter int DECKS        = 1,
  parameter int RESHUFFLE_AT = 6
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] seed_rank,
  input  logic       req_p,
  input  logic       req_d,
  input  logic       round_start,
  output logic [3:0] card_out,
  output logic       ack_p,
  output logic       ack_d,
  output logic [8:0] cards_left,
  output logic       busy,
  output logic       shuffling
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEARCH  = 2'd1,
    S_ACK     = 2'd2,
    S_SHUFFLE = 2'd3
  } state_t;

  localparam logic [5:0] LP_RANK_FULL = 6'(4 * DECKS);
  localparam logic [8:0] LP_SHOE_FULL = 9'(52 * DECKS);
  localparam logic [8:0] LP_RESHUF    = 9'(RESHUFFLE_AT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_cnt [1:13];
  logic [8:0] r_cards_left;
  logic [3:0] r_cand;
  logic [3:0] r_idx;
  logic [3:0] r_card_out;
  logic       r_who;   // 0 = player, 1 = dealer
  logic       r_last;  // side granted most recently

  logic       w_any_req;
  logic       w_cand_hit;
  logic       w_who_nxt;
  logic [3:0] w_seed_norm;

  assign w_any_req   = req_p | req_d;
  assign w_cand_hit  = (r_cnt[r_cand] != 6'd0);
  assign w_seed_norm = ((seed_rank == 4'd0) || (seed_rank > 4'd13)) ? 4'd1 : seed_rank;
  assign w_who_nxt   = (req_p && req_d) ? ~r_last : req_d;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (round_start && (r_cards_left < LP_RESHUF)) begin
          w_state_nxt = S_SHUFFLE;
        end else if (w_any_req && (r_cards_left == 9'd0)) begin
          w_state_nxt = S_SHUFFLE;
        end else if (w_any_req) begin
          w_state_nxt = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (w_cand_hit) begin
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
      end
      S_SHUFFLE: begin
        if (r_idx == 4'd13) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 1; i <= 13; i++) begin
        r_cnt[i] <= LP_RANK_FULL;
      end
      r_cards_left <= LP_SHOE_FULL;
      r_cand       <= 4'd1;
      r_idx        <= 4'd1;
      r_card_out   <= 4'd0;
      r_who        <= 1'b0;
      r_last       <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_state_nxt == S_SHUFFLE) begin
            r_idx <= 4'd1;
          end else if (w_state_nxt == S_SEARCH) begin
            r_who  <= w_who_nxt;
            r_cand <= w_seed_norm;
          end
        end
        S_SEARCH: begin
          // Walk ranks upward with wrap until one still has cards.
          if (w_cand_hit) begin
            r_cnt[r_cand] <= r_cnt[r_cand] - 6'd1;
            r_cards_left  <= r_cards_left - 9'd1;
            r_card_out    <= r_cand;
          end else begin
            r_cand <= (r_cand == 4'd13) ? 4'd1 : r_cand + 4'd1;
          end
        end
        S_ACK: begin
          r_last <= r_who;
        end
        S_SHUFFLE: begin
          r_cnt[r_idx] <= LP_RANK_FULL;
          r_idx        <= r_idx + 4'd1;
          if (r_idx == 4'd13) begin
            r_cards_left <= LP_SHOE_FULL;
          end
        end
        default: ;
      endcase
    end
  end

  assign card_out   = r_card_out;
  assign cards_left = r_cards_left;
  assign ack_p      = (r_state == S_ACK) && !r_who;
  assign ack_d      = (r_state == S_ACK) && r_who;
  assign busy       = (r_state != S_IDLE);
  assign shuffling  = (r_state == S_SHUFFLE);

endmodule

// File: tb/tb_shoe_controller.sv
// tb/tb_shoe_controller.sv - table-driven and randomized checks of shoe_controller
// Expected values come from constants and a per-rank card-count model.
module tb_shoe_controller;

  localparam int DECKS = 1;
  localparam int RESH  = 6;

  logic       slow_clock;
  logic       resetb;
  logic [3:0] seed_rank;
  logic       req_p;
  logic       req_d;
  logic       round_start;
  logic [3:0] card_out;
  logic       ack_p;
  logic       ack_d;
  logic [8:0] cards_left;
  logic       busy;
  logic       shuffling;

  int n_checks;
  int n_err;
  int m_cnt [1:13];
  int m_total;

  typedef struct {
    logic       side;
    logic [3:0] seed;
    int         exp_card;
    int         exp_lat;
    int         exp_left;
  } vec_t;

  vec_t tbl [15];

  shoe_controller #(.DECKS(DECKS), .RESHUFFLE_AT(RESH)) dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .seed_rank  (seed_rank),
    .req_p      (req_p),
    .req_d      (req_d),
    .round_start(round_start),
    .card_out   (card_out),
    .ack_p      (ack_p),
    .ack_d      (ack_d),
    .cards_left (cards_left),
    .busy       (busy),
    .shuffling  (shuffling)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_refill();
    for (int r = 1; r <= 13; r++) m_cnt[r] = 4 * DECKS;
    m_total = 52 * DECKS;
  endtask

  function automatic int norm(input logic [3:0] s);
    if (s == 4'd0 || s > 4'd13) return 1;
    return int'(s);
  endfunction

  task automatic do_reset();
    resetb = 1'b0; req_p = 1'b0; req_d = 1'b0; round_start = 1'b0; seed_rank = 4'd0;
    repeat (3) @(negedge slow_clock);
    resetb = 1'b1;
    @(negedge slow_clock);
    model_refill();
  endtask

  task automatic wait_ack(output int cyc, output logic ap, output logic ad);
    cyc = 0; ap = 1'b0; ad = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge slow_clock);
      round_start = 1'b0;
      if (ack_p || ack_d) begin
        cyc = c; ap = ack_p; ad = ack_d;
        break;
      end
    end
    if (cyc == 0) begin
      n_checks++; n_err++;
      $display("FAIL ack_timeout: got no ack within 60 cycles, expected an ack");
    end
  endtask

  task automatic drive_draw(input logic side, input logic [3:0] seed, input logic rs,
                            output int card, output int lat, output int left);
    logic ap, ad;
    seed_rank = seed; round_start = rs;
    if (side) req_d = 1'b1; else req_p = 1'b1;
    wait_ack(lat, ap, ad);
    card = int'(card_out);
    left = int'(cards_left);
    check("ack_side", int'({ap, ad}), side ? 1 : 2);
    req_p = 1'b0; req_d = 1'b0;
    @(negedge slow_clock);
  endtask

  task automatic model_draw(input logic side, input logic [3:0] seed, input logic rs);
    int r, k, exp_lat, card, lat, left;
    bit sh;
    sh = (m_total == 0);
    if (sh) model_refill();
    r = norm(seed); k = 0;
    while (m_cnt[r] == 0) begin
      r = (r == 13) ? 1 : r + 1;
      k++;
    end
    m_cnt[r]--; m_total--;
    exp_lat = 2 + k + (sh ? 14 : 0);
    drive_draw(side, seed, rs, card, lat, left);
    check("draw_card", card, r);
    check("draw_latency", lat, exp_lat);
    check("draw_left", left, m_total);
  endtask

  task automatic do_round_start();
    int n_sh;
    bit exp_sh;
    n_sh = 0;
    exp_sh = (m_total < RESH);
    round_start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge slow_clock);
      round_start = 1'b0;
      if (shuffling) n_sh++;
    end
    if (exp_sh) model_refill();
    check("shuffle_cycles", n_sh, exp_sh ? 13 : 0);
    check("shuffle_left", int'(cards_left), m_total);
    check("shuffle_idle", int'(busy), 0);
  endtask

  task automatic draw_down_to(input int target);
    while (m_total > target)
      model_draw(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0);
  endtask

  initial begin
    int card, lat, left, cyc, r;
    logic ap, ad;
    n_checks = 0; n_err = 0;

    tbl[0]  = '{1'b0, 4'd5,  5,  2, 51};
    tbl[1]  = '{1'b1, 4'd7,  7,  2, 50};
    tbl[2]  = '{1'b0, 4'd7,  7,  2, 49};
    tbl[3]  = '{1'b1, 4'd7,  7,  2, 48};
    tbl[4]  = '{1'b0, 4'd7,  7,  2, 47};
    tbl[5]  = '{1'b1, 4'd7,  8,  3, 46};
    tbl[6]  = '{1'b0, 4'd0,  1,  2, 45};
    tbl[7]  = '{1'b1, 4'd13, 13, 2, 44};
    tbl[8]  = '{1'b0, 4'd14, 1,  2, 43};
    tbl[9]  = '{1'b1, 4'd15, 1,  2, 42};
    tbl[10] = '{1'b0, 4'd13, 13, 2, 41};
    tbl[11] = '{1'b1, 4'd13, 13, 2, 40};
    tbl[12] = '{1'b0, 4'd13, 13, 2, 39};
    tbl[13] = '{1'b1, 4'd13, 1,  3, 38};
    tbl[14] = '{1'b0, 4'd13, 2,  4, 37};

    do_reset();
    check("rst_card_out", int'(card_out), 0);
    check("rst_acks", int'({ack_p, ack_d}), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_shuffling", int'(shuffling), 0);
    check("rst_cards_left", int'(cards_left), 52 * DECKS);

    for (int i = 0; i < 15; i++) begin
      drive_draw(tbl[i].side, tbl[i].seed, 1'b0, card, lat, left);
      check($sformatf("tbl%0d_card", i), card, tbl[i].exp_card);
      check($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
      check($sformatf("tbl%0d_left", i), left, tbl[i].exp_left);
    end

    // Tie after reset goes to the player, the dealer follows.
    do_reset();
    seed_rank = 4'd4; req_p = 1'b1; req_d = 1'b1;
    wait_ack(cyc, ap, ad);
    check("tie1_first", int'({ap, ad}), 2);
    req_p = 1'b0;
    wait_ack(cyc, ap, ad);
    check("tie1_second", int'({ap, ad}), 1);
    check("tie1_gap", cyc, 3);
    req_d = 1'b0;
    @(negedge slow_clock);
    // After a lone player grant, a tie goes to the dealer.
    drive_draw(1'b0, 4'd4, 1'b0, card, lat, left);
    req_p = 1'b1; req_d = 1'b1;
    wait_ack(cyc, ap, ad);
    check("tie2_first", int'({ap, ad}), 1);
    req_d = 1'b0;
    wait_ack(cyc, ap, ad);
    check("tie2_second", int'({ap, ad}), 2);
    req_p = 1'b0;
    @(negedge slow_clock);

    // Reshuffle threshold at 5 and 6 cards left.
    do_reset();
    draw_down_to(5);
    do_round_start();
    draw_down_to(6);
    r = 1;
    while (m_cnt[r] == 0) r++;
    model_draw(1'b1, 4'(r), 1'b1);
    check("no_shuffle_left", int'(cards_left), 5);

    // Reset while searching aborts the grant and refills the shoe.
    do_reset();
    model_draw(1'b0, 4'd9, 1'b0);
    model_draw(1'b1, 4'd2, 1'b0);
    seed_rank = 4'd3; req_p = 1'b1;
    @(negedge slow_clock);
    check("pre_rst_busy", int'(busy), 1);
    resetb = 1'b0;
    #1;
    check("mid_rst_acks", int'({ack_p, ack_d}), 0);
    check("mid_rst_busy", int'(busy), 0);
    req_p = 1'b0;
    @(negedge slow_clock);
    check("mid_rst_acks2", int'({ack_p, ack_d}), 0);
    resetb = 1'b1;
    @(negedge slow_clock);
    check("post_rst_left", int'(cards_left), 52 * DECKS);
    check("post_rst_busy", int'(busy), 0);
    model_refill();

    // Random draws with occasional round starts, including empty-shoe draws.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) do_round_start();
      model_draw(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/shoe_controller.md
# shoe_controller

Card-shoe manager and draw arbiter for the baccarat datapath. It tracks the remaining cards of each rank in a finite shoe of `DECKS` 52-card decks and serves draw requests from the player-hand and dealer-hand loaders. Each grant returns one card that is actually left in the shoe, skipping exhausted ranks. It sits between the free-running rank generator and the hand registers, and reshuffles on demand at round boundaries.

## Interface
- `DECKS`, default 1: decks in the shoe, legal range 1..8; each rank starts with 4*`DECKS` cards.
- `RESHUFFLE_AT`, default 6: minimum `cards_left` required at `round_start`, otherwise the shoe reshuffles. Legal range 1..52*`DECKS`.
- `slow_clock` in 1: sole clock, rising-edge.
- `resetb` in 1: reset, asynchronous and active-low.
- `seed_rank` in 4: candidate rank from the free-running generator; values 0 and 14..15 are treated as 1.
- `req_p` in 1: player-hand draw request, level, held until `ack_p`.
- `req_d` in 1: dealer-hand draw request, level, held until `ack_d`.
- `round_start` in 1: one-cycle pulse at the start of each round; triggers the reshuffle check.
- `card_out` out 4: rank of the last granted card (1..13); holds until the next grant.
- `ack_p` out 1: one-cycle grant pulse to the player hand; `card_out` is valid in the same cycle.
- `ack_d` out 1: one-cycle grant pulse to the dealer hand; `card_out` is valid in the same cycle.
- `cards_left` out 9: total cards remaining in the shoe.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `shuffling` out 1: high while in SHUFFLE.

## Operation
- Storage:
  - Thirteen 6-bit per-rank counters `cnt[1..13]`.
  - Running total `cards_left`, which always equals the sum of the counters.
- FSM states: IDLE, SEARCH, ACK, SHUFFLE.
- IDLE, evaluated in priority order:
  - (a) `round_start` && `cards_left` < `RESHUFFLE_AT` → SHUFFLE.
  - (b) any request && `cards_left` == 0 → SHUFFLE. The request stays pending and is served afterwards.
  - (c) any request → latch the requester and `cand` = normalised `seed_rank`, then go to SEARCH.
  - A `round_start` that does not trigger a reshuffle does not block (c) in the same cycle.
- Arbitration is round-robin with a `last` flag.
  - When both requests are high, grant the side not served last.
  - `last` resets to dealer, so the player wins the first tie.
  - `ack_p` and `ack_d` are never high together.
- SEARCH, one rank per cycle:
  - If `cnt[cand]` != 0: decrement `cnt[cand]` and `cards_left`, register `card_out` = `cand`, go to ACK.
  - Otherwise set `cand` = (`cand` == 13) ? 1 : `cand`+1 and stay in SEARCH.
  - `cards_left` > 0 is guaranteed on entry, so the search ends within 13 cycles.
- ACK: pulse the latched requester's ack for one cycle, update `last`, go to IDLE.
- SHUFFLE:
  - Index `i` runs 1..13, one counter per cycle: `cnt[i]` = 4*`DECKS`.
  - In the last cycle, `cards_left` = 52*`DECKS`; then go to IDLE.
  - Requests are ignored during SHUFFLE and stay pending.
  - `round_start` during SHUFFLE is ignored.
- Requester rule: `req` must be low in the cycle after its ack. A request still high then is treated as a new draw.

## Timing
- Reset values:
  - `card_out`=0, `ack_p`=`ack_d`=0, `busy`=0, `shuffling`=0.
  - FSM=IDLE, `last`=dealer.
  - All `cnt`=4*`DECKS`, `cards_left`=52*`DECKS`.
- Grant latency:
  - A request sampled in IDLE at cycle n enters SEARCH at n+1.
  - The ack is high at n+2+k, where k is the number of exhausted ranks skipped. The minimum is 2 cycles.
- After ACK, IDLE lasts at least one cycle, so back-to-back grants are at least 3 cycles apart.
- SHUFFLE lasts exactly 13 cycles; `shuffling` is high for exactly those cycles.
- Reset mid-operation (SEARCH, ACK or SHUFFLE):
  - Aborts immediately; no ack is issued.
  - The shoe returns to full.
- Counter updates and `card_out` change on the same edge that enters ACK.

## Test plan
- After reset, `cards_left`=52; `req_p`=1 with `seed_rank`=5 → `ack_p` 2 cycles later, `card_out`=5, `cards_left`=51.
- Draw `seed_rank`=7 four times, then request with `seed_rank`=7 again → `card_out`=8, latency 3, `cnt[7]` stays 0.
- Exhaust rank 13, then request with `seed_rank`=13 → `card_out`=1 (wrap). Request with `seed_rank`=0 → treated as rank 1.
- `req_p` and `req_d` high together after reset → `ack_p` first, `ack_d` on the next grant, never both in one cycle.
- `round_start` with `cards_left`=5 → `shuffling` high for 13 cycles, then `cards_left`=52. With `cards_left`=6 → no shuffle, and a same-cycle `req_d` is served at minimum latency.
- Assert `resetb`=0 during SEARCH → no ack is issued, and after reset `cards_left`=52 and `busy`=0.
